// File: rtl/line_fill_scheduler.sv
// Ping-pong line buffer fill sequencer: on each line start it swaps halves and fetches the next line.
// Optional build macro LFS_UNDERRUN_COUNT_EN adds a saturating overrun counter output.
module line_fill_scheduler #(
  parameter int H_ACTIVE = 32'd640,
  parameter int V_ACTIVE = 32'd480,
  parameter int XW       = 32'd10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          line_start,
  input  logic [XW-1:0] line_y,
  output logic          select,
  output logic          write_en,
  output logic [XW-1:0] write_X,
  output logic [XW-1:0] write_Y,
  output logic [3:0]    write_data,
  output logic          pix_req,
  output logic [XW-1:0] pix_x,
  output logic [XW-1:0] pix_y,
  input  logic          pix_valid,
  input  logic [3:0]    pix_data,
  output logic          busy,
  output logic          underrun,
`ifdef LFS_UNDERRUN_COUNT_EN
  output logic [7:0]    underrun_cnt,
`endif
  input  logic          clr_underrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [XW-1:0] LAST_X = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] LAST_Y = XW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] ONE_X  = XW'(1);
  localparam logic [XW-1:0] ZERO_X = {XW{1'b0}};

  state_t        state_q, state_d;
  logic          select_q, select_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] target_y_q, target_y_d;
  logic          write_en_q, write_en_d;
  logic [XW-1:0] write_x_q, write_x_d;
  logic [XW-1:0] write_y_q, write_y_d;
  logic [3:0]    write_data_q, write_data_d;
  logic          underrun_q, underrun_d;
  logic          accept_s;
  logic          overrun_s;

  // A pixel is taken only while fetching and never in a line-start cycle.
  assign accept_s  = (state_q == ST_FILL) && pix_valid && !line_start;
  assign overrun_s = line_start && (state_q == ST_FILL);

  // Next-state logic: line_start dominates, then pixel acceptance.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    x_d          = x_q;
    target_y_d   = target_y_q;
    write_en_d   = 1'b0;
    write_x_d    = write_x_q;
    write_y_d    = write_y_q;
    write_data_d = write_data_q;
    if (line_start) begin
      select_d   = ~select_q;
      target_y_d = (line_y == LAST_Y) ? ZERO_X : (line_y + ONE_X);
      x_d        = ZERO_X;
      state_d    = ST_FILL;
    end else if (accept_s) begin
      write_en_d   = 1'b1;
      write_x_d    = x_q;
      write_y_d    = target_y_q;
      write_data_d = pix_data;
      if (x_q == LAST_X) begin
        state_d = ST_DONE;
      end else begin
        x_d = x_q + ONE_X;
      end
    end else begin
      state_d = state_q;
    end

    if (overrun_s) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      select_q     <= 1'b0;
      x_q          <= ZERO_X;
      target_y_q   <= ZERO_X;
      write_en_q   <= 1'b0;
      write_x_q    <= ZERO_X;
      write_y_q    <= ZERO_X;
      write_data_q <= 4'd0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      x_q          <= x_d;
      target_y_q   <= target_y_d;
      write_en_q   <= write_en_d;
      write_x_q    <= write_x_d;
      write_y_q    <= write_y_d;
      write_data_q <= write_data_d;
      underrun_q   <= underrun_d;
    end
  end

  assign select     = select_q;
  assign write_en   = write_en_q;
  assign write_X    = write_x_q;
  assign write_Y    = write_y_q;
  assign write_data = write_data_q;
  assign pix_req    = (state_q == ST_FILL);
  assign busy       = (state_q == ST_FILL);
  assign pix_x      = x_q;
  assign pix_y      = target_y_q;
  assign underrun   = underrun_q;

`ifdef LFS_UNDERRUN_COUNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating overrun counter; an increment beats a simultaneous clear.
  always_comb begin
    cnt_d = cnt_q;
    if (overrun_s) begin
      cnt_d = (cnt_q == 8'd255) ? 8'd255 : (cnt_q + 8'd1);
    end else if (clr_underrun) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_line_fill_scheduler.sv
// Randomized scoreboard bench for line_fill_scheduler against a behavioural line-fill model.
module tb_line_fill_scheduler;

  logic       Clk;
  logic       Reset;
  logic       line_start;
  logic [9:0] line_y;
  logic       select;
  logic       write_en;
  logic [9:0] write_X;
  logic [9:0] write_Y;
  logic [3:0] write_data;
  logic       pix_req;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_valid;
  logic [3:0] pix_data;
  logic       busy;
  logic       underrun;
  logic       clr_underrun;
`ifdef LFS_UNDERRUN_COUNT_EN
  logic [7:0] underrun_cnt;
`endif

  line_fill_scheduler dut (
    .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_y(line_y),
    .select(select), .write_en(write_en), .write_X(write_X), .write_Y(write_Y),
    .write_data(write_data), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_data(pix_data), .busy(busy), .underrun(underrun),
`ifdef LFS_UNDERRUN_COUNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .clr_underrun(clr_underrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected writes, packed as {x, y, data}.
  logic [23:0] exp_q[$];

  // Model of the scheduler: mode 0 = idle, 1 = filling, 2 = line done.
  int m_mode = 0, m_sel = 0, m_x = 0, m_ty = 0, m_und = 0, m_cnt = 0;
  int m_wr = 0, m_wx = 0, m_wy = 0, m_wd = 0;
  int writes_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop and compare every write the DUT presents.
  always @(negedge Clk) begin
    if (write_en) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", int'(write_X), -1);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("write_X", int'(write_X), int'(e[23:14]));
        chk("write_Y", int'(write_Y), int'(e[13:4]));
        chk("write_data", int'(write_data), int'(e[3:0]));
      end
    end
  end

  // One clock: check outputs, drive inputs, advance the model, move to next negedge.
  task automatic step(input bit rst_n, input bit ls, input int ly, input bit pv,
                      input int pd, input bit clr);
    chk("select", int'(select), m_sel);
    chk("pix_req", int'(pix_req), (m_mode == 1) ? 1 : 0);
    chk("busy", int'(busy), (m_mode == 1) ? 1 : 0);
    chk("underrun", int'(underrun), m_und);
    chk("write_en", int'(write_en), m_wr);
    chk("write_X_hold", int'(write_X), m_wx);
    chk("write_Y_hold", int'(write_Y), m_wy);
    chk("write_data_hold", int'(write_data), m_wd);
    if (m_mode == 1) begin
      chk("pix_x", int'(pix_x), m_x);
      chk("pix_y", int'(pix_y), m_ty);
    end else if (m_mode == 0) begin
      chk("pix_x_idle", int'(pix_x), 0);
      chk("pix_y_idle", int'(pix_y), 0);
    end
`ifdef LFS_UNDERRUN_COUNT_EN
    chk("underrun_cnt", int'(underrun_cnt), m_cnt);
`endif

    Reset        = rst_n;
    line_start   = ls;
    line_y       = 10'(ly);
    pix_valid    = pv;
    pix_data     = 4'(pd);
    clr_underrun = clr;

    m_wr = 0;
    if (!rst_n) begin
      m_mode = 0; m_sel = 0; m_x = 0; m_ty = 0; m_und = 0; m_cnt = 0;
      m_wx = 0; m_wy = 0; m_wd = 0;
    end else if (ls) begin
      if (m_mode == 1) begin
        m_und = 1;
        if (m_cnt < 255) m_cnt++;
      end else if (clr) begin
        m_und = 0;
        m_cnt = 0;
      end
      m_sel  = 1 - m_sel;
      m_ty   = (ly % 1024 == 479) ? 0 : ((ly % 1024) + 1) % 1024;
      m_x    = 0;
      m_mode = 1;
    end else begin
      if (clr) begin
        m_und = 0;
        m_cnt = 0;
      end
      if (m_mode == 1 && pv) begin
        m_wr = 1;
        m_wx = m_x;
        m_wy = m_ty;
        m_wd = pd % 16;
        exp_q.push_back({10'(m_wx), 10'(m_wy), 4'(m_wd)});
        if (m_x == 639) m_mode = 2;
        else m_x++;
      end
    end
    @(negedge Clk);
  endtask

  // Run the current fill to completion with a given pixel_valid cadence.
  task automatic run_fill(input int period, input int budget, input bit data_is_x);
    int n = 0;
    int k = 0;
    while (m_mode == 1 && n < budget) begin
      bit pv;
      pv = (period <= 1) ? 1'b1 : ((k % period) == period - 1);
      step(1'b1, 1'b0, 0, pv, data_is_x ? (m_x % 16) : int'($urandom_range(15)), 1'b0);
      k++;
      n++;
    end
    chk("fill_completed_in_budget", m_mode, 2);
  endtask

  initial begin
    int ws;
    Reset = 1'b0; line_start = 1'b0; line_y = 10'd0;
    pix_valid = 1'b0; pix_data = 4'd0; clr_underrun = 1'b0;
    @(negedge Clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 5, 1'b0);

    // Full-rate fill of line 10.
    ws = writes_seen;
    step(1'b1, 1'b1, 10, 1'b1, 3, 1'b0);
    run_fill(1, 700, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 7, 1'b0);
    chk("full_rate_write_count", writes_seen - ws, 640);

    // Renderer answering every third cycle, data = column low bits.
    ws = writes_seen;
    step(1'b1, 1'b1, $urandom_range(470), 1'b0, 0, 1'b0);
    run_fill(3, 2100, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("slow_rate_write_count", writes_seen - ws, 640);

    // Last visible line wraps to row 0.
    step(1'b1, 1'b1, 479, 1'b0, 0, 1'b0);
    run_fill(2, 1400, 1'b0);

    // Overrun after 100 accepts, with pix_valid in the pulse cycle, then clear.
    step(1'b1, 1'b1, 50, 1'b0, 0, 1'b0);
    while (m_x < 100) step(1'b1, 1'b0, 0, 1'b1, $urandom_range(15), 1'b0);
    step(1'b1, 1'b1, 200, 1'b1, 9, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 1'b1, $urandom_range(15), 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Reset in the middle of a fill, then pix_valid while idle.
    step(1'b1, 1'b1, 300, 1'b0, 0, 1'b0);
    while (m_x < 300) step(1'b1, 1'b0, 0, 1'b1, $urandom_range(15), 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 4, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 1'b1, $urandom_range(15), 1'b0);

    // Burst of overruns: 3, then 260 total, then clear.
    step(1'b1, 1'b1, 20, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 20, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 257; i++) step(1'b1, 1'b1, $urandom_range(1023), 1'b0, 0, (i % 7) == 0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Random traffic, including out-of-range line_y values.
    for (int i = 0; i < 3000; i++) begin
      bit rst_n, ls, pv, clr;
      rst_n = ($urandom_range(1999) != 0);
      ls    = ($urandom_range(399) == 0);
      pv    = $urandom_range(1);
      clr   = ($urandom_range(49) == 0);
      step(rst_n, ls, $urandom_range(1023), pv, $urandom_range(15), clr);
    end

    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
